// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: holds the PLL in reset, qualifies its lock output,
// then releases the downstream clock-domain resets one by one in ascending
// order. Loss of lock or a relock request restarts the whole sequence.
module pll_reset_sequencer #(
  parameter int unsigned NUM_DOMAINS    = 5,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned RELEASE_GAP    = 64,
  parameter int unsigned CNT_W          = 17
) (
  input  logic                   refclk_i,
  input  logic                   rst_i,
  input  logic                   pll_locked_i,
  input  logic                   relock_req_i,
  output logic                   pll_rst_o,
  output logic [NUM_DOMAINS-1:0] domain_rst_o,
  output logic                   ready_o,
  output logic [1:0]             state_o,
  output logic [7:0]             lock_lost_cnt_o,
  output logic [7:0]             timeout_cnt_o
);

  typedef enum logic [1:0] {
    StPllRst   = 2'd0,
    StWaitLock = 2'd1,
    StRelease  = 2'd2,
    StRun      = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RstLast   = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TmoLast   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GapLast   = CNT_W'(RELEASE_GAP - 1);
  localparam logic [CNT_W-1:0] StableTgt = CNT_W'(LOCK_STABLE);

  localparam logic [NUM_DOMAINS-1:0] AllRst   = '1;
  // Domain 0 is already released in the first RELEASE cycle.
  localparam logic [NUM_DOMAINS-1:0] FirstRel = AllRst << 1;

  logic                   sync1_q, sync2_q;
  state_e                 state_q;
  // Shared phase counter: hold time in PLLRST, timeout in WAIT_LOCK, gap in RELEASE.
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       stable_q;
  logic                   pll_rst_q;
  logic [NUM_DOMAINS-1:0] domain_rst_q;
  logic                   ready_q;
  logic [7:0]             lost_q;
  logic [7:0]             tmo_q;

  logic [CNT_W-1:0]       stable_d;
  logic                   restart;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked_i;
      sync2_q <= sync1_q;
    end
  end

  // Next consecutive-lock count and the restart trigger for RELEASE/RUN.
  always_comb begin
    stable_d = sync2_q ? stable_q + 1'b1 : '0;
    restart  = !sync2_q || relock_req_i;
  end

  // Sequencing FSM with registered outputs and saturating status counters.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q      <= StPllRst;
      cnt_q        <= '0;
      stable_q     <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= AllRst;
      ready_q      <= 1'b0;
      lost_q       <= '0;
      tmo_q        <= '0;
    end else begin
      case (state_q)
        StPllRst: begin
          if (cnt_q == RstLast) begin
            state_q   <= StWaitLock;
            pll_rst_q <= 1'b0;
            cnt_q     <= '0;
            stable_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitLock: begin
          stable_q <= stable_d;
          // Stable lock wins over a timeout landing in the same cycle.
          if (stable_d == StableTgt) begin
            state_q      <= StRelease;
            cnt_q        <= '0;
            domain_rst_q <= FirstRel;
          end else if (cnt_q == TmoLast) begin
            state_q   <= StPllRst;
            pll_rst_q <= 1'b1;
            cnt_q     <= '0;
            if (tmo_q != 8'hFF) tmo_q <= tmo_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRelease, StRun: begin
          // A restart overrides any release step due in the same cycle.
          if (restart) begin
            state_q      <= StPllRst;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= AllRst;
            ready_q      <= 1'b0;
            cnt_q        <= '0;
            if (!sync2_q && lost_q != 8'hFF) lost_q <= lost_q + 1'b1;
          end else if (state_q == StRelease) begin
            if (domain_rst_q == '0) begin
              state_q <= StRun;
              ready_q <= 1'b1;
            end else if (cnt_q == GapLast) begin
              // Shifting in a zero releases the next domain in index order.
              domain_rst_q <= domain_rst_q << 1;
              cnt_q        <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StPllRst;
      endcase
    end
  end

  assign pll_rst_o       = pll_rst_q;
  assign domain_rst_o    = domain_rst_q;
  assign ready_o         = ready_q;
  assign state_o         = state_q;
  assign lock_lost_cnt_o = lost_q;
  assign timeout_cnt_o   = tmo_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: directed scenarios plus random lock
// noise, checked cycle by cycle against a phase/elapsed-time reference model.
module tb_pll_reset_sequencer;

  localparam int N   = 5;
  localparam int PRC = 4;
  localparam int STB = 8;
  localparam int TMO = 32;
  localparam int GAP = 3;
  localparam int CW  = 17;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pll_locked = 1'b0;
  logic         relock_req = 1'b0;
  logic         pll_rst;
  logic [N-1:0] domain_rst;
  logic         ready;
  logic [1:0]   state;
  logic [7:0]   lost_cnt;
  logic [7:0]   tmo_cnt;

  pll_reset_sequencer #(
    .NUM_DOMAINS   (N),
    .PLL_RST_CYCLES(PRC),
    .LOCK_STABLE   (STB),
    .LOCK_TIMEOUT  (TMO),
    .RELEASE_GAP   (GAP),
    .CNT_W         (CW)
  ) dut (
    .refclk_i       (clk),
    .rst_i          (rst),
    .pll_locked_i   (pll_locked),
    .relock_req_i   (relock_req),
    .pll_rst_o      (pll_rst),
    .domain_rst_o   (domain_rst),
    .ready_o        (ready),
    .state_o        (state),
    .lock_lost_cnt_o(lost_cnt),
    .timeout_cnt_o  (tmo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   st;
    logic         prst;
    logic [N-1:0] dom;
    logic         rdy;
    logic [7:0]   lost;
    logic [7:0]   tmo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: phase (0..3), cycles elapsed in phase, run of
  // consecutive synchronized-lock cycles, and the two status counts.
  int m_phase = 0;
  int m_t     = 0;
  int m_run   = 0;
  int m_lost  = 0;
  int m_tmo   = 0;
  bit lk_hist[$] = '{1'b0, 1'b0};

  task automatic model_step(input bit r, input bit pl, input bit rq);
    bit ls;
    if (r) begin
      m_phase = 0; m_t = 0; m_run = 0; m_lost = 0; m_tmo = 0;
      lk_hist = '{1'b0, 1'b0};
      return;
    end
    // The FSM sees pll_locked as it was two edges earlier.
    ls = lk_hist.pop_front();
    lk_hist.push_back(pl);
    case (m_phase)
      0: begin
        if (m_t == PRC - 1) begin m_phase = 1; m_t = 0; m_run = 0; end
        else m_t++;
      end
      1: begin
        m_run = ls ? m_run + 1 : 0;
        if (m_run == STB) begin m_phase = 2; m_t = 0; end
        else if (m_t + 1 == TMO) begin
          m_phase = 0; m_t = 0;
          if (m_tmo < 255) m_tmo++;
        end else m_t++;
      end
      default: begin
        if (!ls || rq) begin
          if (!ls && m_lost < 255) m_lost++;
          m_phase = 0; m_t = 0;
        end else if (m_phase == 2) begin
          if (m_t >= (N - 1) * GAP) begin m_phase = 3; m_t = 0; end
          else m_t++;
        end
      end
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.st   = 2'(m_phase);
    e.prst = (m_phase == 0);
    e.rdy  = (m_phase == 3);
    e.lost = 8'(m_lost);
    e.tmo  = 8'(m_tmo);
    for (int i = 0; i < N; i++) begin
      if (m_phase == 2)      e.dom[i] = (i * GAP > m_t);
      else if (m_phase == 3) e.dom[i] = 1'b0;
      else                   e.dom[i] = 1'b1;
    end
    return e;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input bit r, input bit pl, input bit rq);
    @(negedge clk);
    rst        = r;
    pll_locked = pl;
    relock_req = rq;
    model_step(r, pl, rq);
    exp_q.push_back(model_out());
  endtask

  task automatic run_until(input int ph, input int t, input int budget, input string name);
    int n = 0;
    while (!(m_phase == ph && m_t == t) && n < budget) begin
      step(1'b0, 1'b1, 1'b0);
      n++;
    end
    checks++;
    if (!(m_phase == ph && m_t == t)) begin
      errors++;
      $display("FAIL %s: phase %0d t %0d reached, required phase %0d t %0d", name, m_phase, m_t,
               ph, t);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("pll_rst", 32'(pll_rst), 32'(e.prst));
        chk("domain_rst", 32'(domain_rst), 32'(e.dom));
        chk("ready", 32'(ready), 32'(e.rdy));
        chk("lock_lost_cnt", 32'(lost_cnt), 32'(e.lost));
        chk("timeout_cnt", 32'(tmo_cnt), 32'(e.tmo));
      end
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b0, 1'b0);

    // Normal bring-up, lock appears a few cycles after PLL reset ends.
    repeat (6) step(1'b0, 1'b0, 1'b0);
    repeat (45) step(1'b0, 1'b1, 1'b0);

    // Glitchy lock restarts the stability count.
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (40) step(1'b0, 1'b1, 1'b0);

    // Timeouts, then enough of them to saturate the counter.
    step(1'b1, 1'b0, 1'b0);
    repeat (80) step(1'b0, 1'b0, 1'b0);
    repeat (258 * (PRC + TMO)) step(1'b0, 1'b0, 1'b0);

    // Lock loss in RUN.
    step(1'b1, 1'b0, 1'b0);
    run_until(3, 0, 200, "reach_run_1");
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run_until(3, 0, 200, "reach_run_2");

    // relock_req in RUN, mid-RELEASE (11100), and in WAIT_LOCK.
    step(1'b0, 1'b1, 1'b1);
    run_until(2, 4, 200, "reach_release_t4");
    step(1'b0, 1'b1, 1'b1);
    run_until(1, 2, 200, "reach_wait_lock");
    step(1'b0, 1'b1, 1'b1);
    run_until(3, 0, 200, "reach_run_3");

    // rst during RELEASE.
    step(1'b0, 1'b1, 1'b1);
    run_until(2, 5, 200, "reach_release_t5");
    step(1'b1, 1'b1, 1'b0);

    // Lock loss that lands exactly on a scheduled release step.
    run_until(2, 0, 200, "reach_release_t0");
    step(1'b0, 1'b0, 1'b0);
    repeat (40) step(1'b0, 1'b1, 1'b0);

    // Random lock noise, relock requests and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 99) < 97),
           ($urandom_range(0, 199) == 0));
    end

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Supervises the multi-output clock PLL: drives the PLL reset, qualifies its lock indication and releases per-clock-domain resets in a fixed order.
- Detects loss of lock and re-runs the full sequence.
- Sits on the PLL reference-clock domain, between the top-level reset and the core's clock domains (video, CPU, sound, pixel, shifted pixel).

Parameters:
NUM_DOMAINS, 5, number of downstream domain resets; one per PLL output clock.
PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt.
LOCK_STABLE, 1024, consecutive synchronized-locked cycles required before release.
LOCK_TIMEOUT, 65536, maximum cycles in WAIT_LOCK before a retry.
RELEASE_GAP, 64, cycles between successive domain reset releases.
CNT_W, 17, width of the internal counters; must hold LOCK_TIMEOUT.

Ports:
refclk  in  1  sole clock; PLL reference clock.
rst  in  1  synchronous, active-high reset.
pll_locked  in  1  PLL lock output; asynchronous to refclk.
relock_req  in  1  single-cycle request to force a full PLL re-lock.
pll_rst  out  1  drives the PLL reset input.
domain_rst  out  NUM_DOMAINS  active-high per-domain resets; bit i is for outclk_i.
ready  out  1  all domains released and lock held.
state  out  2  0=PLLRST, 1=WAIT_LOCK, 2=RELEASE, 3=RUN.
lock_lost_cnt  out  8  count of lock losses while in RELEASE or RUN; saturates at 255.
timeout_cnt  out  8  count of WAIT_LOCK timeouts; saturates at 255.

Behaviour:
- All state is synchronous to refclk. rst is sampled only on refclk edges and has priority over everything.
- Reset values:
  - state=PLLRST, pll_rst=1, domain_rst=all 1, ready=0.
  - Both counters 0; synchronizer flops 0; internal counters 0.
- pll_locked passes through a 2-flop synchronizer to give locked_s, so there is 2 cycles of latency.
- PLLRST:
  - pll_rst=1 and domain_rst=all 1.
  - Counts PLL_RST_CYCLES cycles, then goes to WAIT_LOCK. pll_rst is 0 from the first WAIT_LOCK cycle.
  - After rst deasserts, pll_rst is high for exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - stable_cnt increments each cycle locked_s=1 and clears to 0 when locked_s=0.
  - When stable_cnt reaches LOCK_STABLE, go to RELEASE.
  - tmo_cnt counts every cycle in this state. When it reaches LOCK_TIMEOUT without stable, go to PLLRST and increment timeout_cnt.
  - If both conditions hit in the same cycle, stable wins.
- RELEASE:
  - domain_rst[0] clears in the first RELEASE cycle.
  - Each following bit clears RELEASE_GAP cycles after the previous one, in ascending index order.
  - One cycle after the last bit clears, go to RUN. ready=1 from the first RUN cycle.
- RUN: hold all outputs steady.
- Lock loss or relock (applies in RELEASE or RUN):
  - Trigger: locked_s=0 or relock_req=1.
  - Next cycle: domain_rst=all 1, ready=0, state=PLLRST, pll_rst=1.
  - lock_lost_cnt increments only for locked_s=0, not for relock_req alone, and by at most 1 per event.
  - This takes precedence over a release step scheduled in the same cycle.
- relock_req in PLLRST or WAIT_LOCK: ignored. In WAIT_LOCK, locked_s=0 only clears stable_cnt.
- A domain reset is never released while pll_rst=1 or before LOCK_STABLE is met. The release order is never permuted.
- Both status counters saturate and do not wrap. Only rst clears them.
- rst asserted mid-sequence, in any state: the next cycle returns to the reset values; the status counters clear.

Test Plan:
Common parameters: PLL_RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, RELEASE_GAP=3, NUM_DOMAINS=5.
1. Normal bring-up: release rst at cycle 0; pll_locked=1 from cycle 6 -> pll_rst high for cycles 1-4; state=RELEASE once locked_s has been high 8 cycles; domain_rst goes 11111 -> 11110 -> 11100 -> 11000 -> 10000 -> 00000 at 3-cycle spacing; ready=1 one cycle later.
2. Glitchy lock: pll_locked high 5 cycles, low 1, then high -> stable_cnt restarts; release occurs 8 cycles after the final rise plus 2 synchronizer cycles.
3. Timeout: pll_locked held 0 -> state cycles PLLRST -> WAIT_LOCK (32 cycles) -> PLLRST; timeout_cnt=1, then 2; domain_rst stays 11111; saturation check at 255 after forcing 256 timeouts.
4. Lock loss in RUN: drop pll_locked for 1 cycle -> 2 cycles later domain_rst=11111, ready=0, pll_rst=1, lock_lost_cnt=1; full sequence repeats.
5. relock_req in RUN and mid-RELEASE (domain_rst=11100) -> next cycle domain_rst=11111, state=PLLRST, lock_lost_cnt unchanged; relock_req in WAIT_LOCK ignored.
6. rst asserted during RELEASE, and simultaneous lock loss with a scheduled release step -> reset values next cycle; lock loss wins and no bit is released.
